// File: rtl/conv_1d_line_feeder.sv
// conv_1d_line_feeder
//   Streaming front-end for the parallel ternary 1-D convolution engine. Collects one
//   IMG_D-channel column per handshake beat into a double-buffered line store, transposed
//   into the engine's flattened layout (element (k,c) at index k*IMG_W+c). Each
//   completed line is presented for a single cycle on lines_out, tagged on opaque_out.
//
//   Optional feature macro: CONV1D_FEEDER_CREDIT_EN
//     defined   - launches are gated by a credit counter (CREDITS lines in flight),
//                 replenished by credit_return pulses.
//     undefined - no credit counter; a line launches as soon as it is complete and
//                 credit_return is ignored.
//
// Ports
//   clk            clock
//   reset          asynchronous active-low reset
//   s_valid        column beat valid
//   s_ready        feeder can accept a beat (depends on registered state only)
//   s_data         one column; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_last         final column of a line
//   credit_return  one-cycle pulse: downstream drained one line
//   lines_out      launched line, element (k,c) at index k*IMG_W+c
//   opaque_out     bit0 = launch valid, bits[7:1] = line sequence number
//   err_framing    sticky framing error (early or missing s_last)

module conv_1d_line_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 32,
    parameter int unsigned IMG_D      = 8,
    parameter int unsigned CREDITS    = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [DATA_WIDTH*IMG_D-1:0]         s_data,
    input  logic                                s_last,
    input  logic                                credit_return,
    output logic [DATA_WIDTH*IMG_D*IMG_W-1:0]   lines_out,
    output logic [7:0]                          opaque_out,
    output logic                                err_framing
);

    localparam int unsigned LineW = DATA_WIDTH * IMG_D * IMG_W;
    localparam int unsigned ColW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(IMG_W - 1);

    logic [LineW-1:0] line_buf_q [2];
    logic [1:0]       full_q;
    logic             wptr_q;
    logic             rptr_q;
    logic [ColW-1:0]  wcol_q;
    logic [6:0]       seq_q;
    logic             err_q;
    logic [7:0]       opaque_q;
    logic [LineW-1:0] lines_q;

    logic accept;
    logic at_last_col;
    logic close;
    logic launch;

    assign s_ready     = !full_q[wptr_q];
    assign accept      = s_valid && s_ready;
    assign at_last_col = (wcol_q == LastCol);
    assign close       = accept && (at_last_col || s_last);

`ifdef CONV1D_FEEDER_CREDIT_EN
    logic [3:0] credits_q;
    logic [3:0] credits_d;

    assign launch = full_q[rptr_q] && (credits_q != 4'd0);

    // A launch and a returned credit in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        if (launch && !credit_return) begin
            credits_d = credits_q - 4'd1;
        end else if (!launch && credit_return && (credits_q != 4'(CREDITS))) begin
            credits_d = credits_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_q <= 4'(CREDITS);
        end else begin
            credits_q <= credits_d;
        end
    end
`else
    logic unused_credit_return;

    assign launch               = full_q[rptr_q];
    assign unused_credit_return = credit_return;
`endif

    // Line store. A launch zeroes the released buffer so that an early-closed line reads
    // zero in its unfilled columns. A launch always targets the full buffer while an
    // accepted beat always targets the empty one, so the two never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_buf_q[0] <= '0;
            line_buf_q[1] <= '0;
        end else begin
            if (launch) begin
                line_buf_q[rptr_q] <= '0;
            end
            if (accept) begin
                for (int unsigned k = 0; k < IMG_D; k++) begin
                    line_buf_q[wptr_q][(k * IMG_W + 32'(wcol_q)) * DATA_WIDTH +: DATA_WIDTH]
                        <= s_data[k * DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q   <= 2'b00;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            wcol_q   <= '0;
            seq_q    <= 7'd0;
            err_q    <= 1'b0;
            opaque_q <= 8'h00;
            lines_q  <= '0;
        end else begin
            if (close) begin
                full_q[wptr_q] <= 1'b1;
                wptr_q         <= !wptr_q;
                wcol_q         <= '0;
            end else if (accept) begin
                wcol_q <= wcol_q + 1'b1;
            end

            if (launch) begin
                full_q[rptr_q] <= 1'b0;
                rptr_q         <= !rptr_q;
                seq_q          <= seq_q + 7'd1;
                lines_q        <= line_buf_q[rptr_q];
                opaque_q       <= {seq_q, 1'b1};
            end else begin
                opaque_q <= 8'h00;
            end

            // Framing error: s_last early, or missing on the final column.
            if (accept && (s_last != at_last_col)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign lines_out   = lines_q;
    assign opaque_out  = opaque_q;
    assign err_framing = err_q;

endmodule

// File: tb/tb_conv_1d_line_feeder.sv
module tb_conv_1d_line_feeder;

    localparam int DW = 8;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int LW = DW * D * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW*D-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          credit_return = 1'b0;
    logic [LW-1:0] lines_out;
    logic [7:0]    opaque_out;
    logic          err_framing;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;
    int launches = 0;
    logic [6:0] seq_log [$];

    conv_1d_line_feeder #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_D      (D),
        .CREDITS    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .credit_return (credit_return),
        .lines_out     (lines_out),
        .opaque_out    (opaque_out),
        .err_framing   (err_framing)
    );

    always #5 clk = ~clk;

    // Launch log, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (opaque_out[0]) begin
            launches++;
            seq_log.push_back(opaque_out[7:1]);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW*D-1:0] column(input int tag, input int c);
        logic [DW*D-1:0] col;
        col = '0;
        for (int k = 0; k < D; k++) col[k*DW +: DW] = 8'(8 * c + k + 3 * tag);
        return col;
    endfunction

    function automatic logic [LW-1:0] build_line(input int tag, input int ncols);
        logic [LW-1:0] v;
        v = '0;
        for (int k = 0; k < D; k++)
            for (int c = 0; c < ncols; c++)
                v[(k * W + c) * DW +: DW] = 8'(8 * c + k + 3 * tag);
        return v;
    endfunction

    function automatic int first_diff(input logic [LW-1:0] a, input logic [LW-1:0] b);
        for (int i = 0; i < D * W; i++) if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        return 0;
    endfunction

    task automatic send_line(input int tag, input int nbeats, input bit with_last);
        bit acc;
        int guard;
        for (int c = 0; c < nbeats; c++) begin
            s_valid = 1'b1;
            s_data  = column(tag, c);
            s_last  = with_last && (c == nbeats - 1);
            guard   = 0;
            do begin
                acc = s_ready;
                if (!acc) stall_cycles++;
                @(posedge clk);
                #1;
                guard++;
            end while (!acc && guard < 200);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_line_timeout: s_ready=%0b required 1", s_ready);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic give_credit();
        credit_return = 1'b1;
        @(posedge clk);
        #1;
        credit_return = 1'b0;
    endtask

    task automatic apply_reset();
        s_valid = 1'b0;
        s_last = 1'b0;
        credit_return = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        launches = 0;
        seq_log.delete();
    endtask

    task automatic test_reset();
        s_valid = 1'b0;
        #1;
        reset = 1'b0;
        #3;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_s_ready: got %0b required 1", s_ready);
        end
        checks++;
        if (opaque_out !== 8'h00) begin
            errors++; $display("FAIL reset_opaque: got %0h required 00", opaque_out);
        end
        checks++;
        if (lines_out !== '0) begin
            errors++; $display("FAIL reset_lines: nonzero element %0d", first_diff(lines_out, '0));
        end
        checks++;
        if (err_framing !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %0b required 0", err_framing);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        launches = 0;
        seq_log.delete();
    endtask

    task automatic test_basic_line();
        logic [LW-1:0] exp;
        exp = build_line(0, 32);
        send_line(0, 32, 1'b1);
        checks++;
        if (opaque_out !== 8'h00) begin
            errors++; $display("FAIL basic_early_launch: opaque got %0h required 00", opaque_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (opaque_out !== 8'h01) begin
            errors++; $display("FAIL basic_opaque: got %0h required 01", opaque_out);
        end
        checks++;
        if (lines_out !== exp) begin
            errors++;
            $display("FAIL basic_lines: element %0d got %0h required %0h", first_diff(lines_out, exp),
                     lines_out[first_diff(lines_out, exp)*DW +: DW],
                     exp[first_diff(lines_out, exp)*DW +: DW]);
        end
        checks++;
        if (err_framing !== 1'b0) begin
            errors++; $display("FAIL basic_err: got %0b required 0", err_framing);
        end
        @(posedge clk);
        #1;
        checks++;
        if (opaque_out !== 8'h00) begin
            errors++; $display("FAIL basic_opaque_drop: got %0h required 00", opaque_out);
        end
        checks++;
        if (lines_out !== exp) begin
            errors++; $display("FAIL basic_lines_hold: element %0d differs", first_diff(lines_out, exp));
        end
    endtask

    // Ten lines back to back; sequence continues from 1.
    task automatic test_stream();
        logic [LW-1:0] exp;
        launches = 0;
        seq_log.delete();
        stall_cycles = 0;
        for (int l = 0; l < 10; l++) begin
            send_line(1 + l, 32, 1'b1);
`ifdef CONV1D_FEEDER_CREDIT_EN
            give_credit();
`endif
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (launches !== 10) begin
            errors++; $display("FAIL stream_launches: got %0d required 10", launches);
        end
        for (int i = 0; i < seq_log.size(); i++) begin
            checks++;
            if (seq_log[i] !== 7'(1 + i)) begin
                errors++; $display("FAIL stream_seq[%0d]: got %0d required %0d", i, seq_log[i], 1 + i);
            end
        end
        checks++;
        if (stall_cycles !== 0) begin
            errors++; $display("FAIL stream_stalls: got %0d required 0", stall_cycles);
        end
        exp = build_line(10, 32);
        checks++;
        if (lines_out !== exp) begin
            errors++; $display("FAIL stream_last_line: element %0d differs", first_diff(lines_out, exp));
        end
    endtask

    // s_last on beat 9 into a reused buffer; columns 10..31 must read zero.
    task automatic test_early_close();
        logic [LW-1:0] exp;
        send_line(20, 10, 1'b1);
        checks++;
        if (err_framing !== 1'b1) begin
            errors++; $display("FAIL early_err_set: got %0b required 1", err_framing);
        end
        @(posedge clk);
        #1;
        checks++;
        if (opaque_out !== {7'd11, 1'b1}) begin
            errors++; $display("FAIL early_opaque: got %0h required %0h", opaque_out, {7'd11, 1'b1});
        end
        exp = build_line(20, 10);
        checks++;
        if (lines_out !== exp) begin
            errors++;
            $display("FAIL early_lines: element %0d got %0h required %0h", first_diff(lines_out, exp),
                     lines_out[first_diff(lines_out, exp)*DW +: DW],
                     exp[first_diff(lines_out, exp)*DW +: DW]);
        end
        send_line(21, 32, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (opaque_out !== {7'd12, 1'b1}) begin
            errors++; $display("FAIL early_clean_opaque: got %0h required %0h", opaque_out, {7'd12, 1'b1});
        end
        exp = build_line(21, 32);
        checks++;
        if (lines_out !== exp) begin
            errors++; $display("FAIL early_clean_lines: element %0d differs", first_diff(lines_out, exp));
        end
        checks++;
        if (err_framing !== 1'b1) begin
            errors++; $display("FAIL early_err_sticky: got %0b required 1", err_framing);
        end
    endtask

`ifdef CONV1D_FEEDER_CREDIT_EN
    task automatic test_credit_stall();
        logic [LW-1:0] exp;
        apply_reset();
        for (int l = 0; l < 6; l++) send_line(30 + l, 32, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (launches !== 4) begin
            errors++; $display("FAIL credit_launches: got %0d required 4", launches);
        end
        for (int i = 0; i < seq_log.size(); i++) begin
            checks++;
            if (seq_log[i] !== 7'(i)) begin
                errors++; $display("FAIL credit_seq[%0d]: got %0d required %0d", i, seq_log[i], i);
            end
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL credit_ready_low: got %0b required 0", s_ready);
        end
        credit_return = 1'b1;
        @(posedge clk);
        #1;
        credit_return = 1'b0;
        checks++;
        if (opaque_out !== 8'h00) begin
            errors++; $display("FAIL credit_no_launch_yet: got %0h required 00", opaque_out);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL credit_ready_still_low: got %0b required 0", s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (opaque_out !== {7'd4, 1'b1}) begin
            errors++; $display("FAIL credit_launch: got %0h required %0h", opaque_out, {7'd4, 1'b1});
        end
        exp = build_line(34, 32);
        checks++;
        if (lines_out !== exp) begin
            errors++; $display("FAIL credit_lines: element %0d differs", first_diff(lines_out, exp));
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL credit_ready_back: got %0b required 1", s_ready);
        end
    endtask
`endif

    // 130 lines: sequence numbers wrap 127 -> 0.
    task automatic test_seq_wrap();
        apply_reset();
        for (int l = 0; l < 130; l++) begin
            send_line(l, 32, 1'b1);
            give_credit();
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (launches !== 130) begin
            errors++; $display("FAIL wrap_launches: got %0d required 130", launches);
        end
        for (int i = 0; i < seq_log.size(); i++) begin
            checks++;
            if (seq_log[i] !== 7'(i % 128)) begin
                errors++; $display("FAIL wrap_seq[%0d]: got %0d required %0d", i, seq_log[i], i % 128);
            end
        end
        checks++;
        if (err_framing !== 1'b0) begin
            errors++; $display("FAIL wrap_err: got %0b required 0", err_framing);
        end
    endtask

    task automatic test_reset_mid_line();
        logic [LW-1:0] exp;
        send_line(40, 32, 1'b1);
        send_line(41, 17, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_ready: got %0b required 1", s_ready);
        end
        checks++;
        if (opaque_out !== 8'h00) begin
            errors++; $display("FAIL midreset_opaque: got %0h required 00", opaque_out);
        end
        checks++;
        if (lines_out !== '0) begin
            errors++; $display("FAIL midreset_lines: nonzero element %0d", first_diff(lines_out, '0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        launches = 0;
        seq_log.delete();
        send_line(42, 32, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (opaque_out !== 8'h01) begin
            errors++; $display("FAIL midreset_opaque_after: got %0h required 01", opaque_out);
        end
        exp = build_line(42, 32);
        checks++;
        if (lines_out !== exp) begin
            errors++; $display("FAIL midreset_lines_after: element %0d differs", first_diff(lines_out, exp));
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_stream();
        test_early_close();
`ifdef CONV1D_FEEDER_CREDIT_EN
        test_credit_stall();
`endif
        test_seq_wrap();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
